// File: rtl/pre_pc_pkg.sv
// Shared widths, reset constants and FSM encoding for the instruction prefetch unit.
package pre_pc_pkg;

    localparam int          InstAddrBus = 64;
    localparam int          InstBus     = 32;
    localparam logic [63:0] PcInit      = 64'h8000_0000;
    localparam logic [63:0] RegZero     = 64'h0;
    localparam int          LINE_WORDS  = 16;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StReq  = 2'd1;
    localparam logic [1:0] StWait = 2'd2;
    localparam logic [1:0] StHold = 2'd3;

    typedef enum logic [1:0] {
        IDLE = StIdle,
        REQ  = StReq,
        WAIT = StWait,
        HOLD = StHold
    } FsmState;

endpackage

// File: rtl/pre_pc_if.sv
// Instruction-memory read bus: single-outstanding valid/ready request, one-cycle response strobe.
interface pre_pc_if #(
    parameter int ADDR_W = pre_pc_pkg::InstAddrBus,
    parameter int INST_W = pre_pc_pkg::InstBus
);
    import pre_pc_pkg::*;

    logic              ReadReqValid;
    logic              ReadReqReady;
    logic [ADDR_W-1:0] ReadAddr;
    logic              ReadRespValid;
    logic [INST_W-1:0] ReadRespData;

    modport master (
        output ReadReqValid,
        output ReadAddr,
        input  ReadReqReady,
        input  ReadRespValid,
        input  ReadRespData
    );

    modport slave (
        input  ReadReqValid,
        input  ReadAddr,
        output ReadReqReady,
        output ReadRespValid,
        output ReadRespData
    );

endinterface

// File: rtl/pre_pc.sv
// Prefetches sequential instructions into the Ifu I-Cache until full; restarts from Pc on a miss.
// Latency: request cycle, response cycle, then a registered ReadShakeHands strobe (3 cycles/word on a zero-wait bus).
// Backpressure: ReadReqValid and ReadAddr hold until ReadReqReady; a miss may withdraw an unaccepted request.
module pre_pc #(
    parameter int                ADDR_W     = pre_pc_pkg::InstAddrBus,
    parameter int                INST_W     = pre_pc_pkg::InstBus,
    parameter logic [ADDR_W-1:0] PC_INIT    = ADDR_W'(pre_pc_pkg::PcInit),
    parameter int                LINE_WORDS = pre_pc_pkg::LINE_WORDS
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W-1:0] PcIn,
    input  logic              CacheFull,
    input  logic              CacheMissing,
    pre_pc_if.master          memBus,
    output logic [ADDR_W-1:0] PrePcOut,
    output logic [INST_W-1:0] InstOut,
    output logic              ReadShakeHands
);
    import pre_pc_pkg::*;

    localparam int CNT_W = $clog2(LINE_WORDS + 1);

    FsmState           state;
    logic [ADDR_W-1:0] NextAddr;
    logic [ADDR_W-1:0] PendAddr;
    logic [ADDR_W-1:0] RestartAddr;
    logic [CNT_W-1:0]  FillCnt;
    logic              Restart;
    logic              StopPend;

    logic [ADDR_W-1:0] missAddr;
    logic              reqFire;
    logic              lastFill;

    always_comb begin
        missAddr = {PcIn[ADDR_W-1:2], 2'b00};
        reqFire  = memBus.ReadReqValid && memBus.ReadReqReady;
        lastFill = (FillCnt == CNT_W'(LINE_WORDS - 1));
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state               <= IDLE;
            NextAddr            <= PC_INIT;
            PendAddr            <= PC_INIT;
            RestartAddr         <= PC_INIT;
            FillCnt             <= '0;
            Restart             <= 1'b0;
            StopPend            <= 1'b0;
            memBus.ReadReqValid <= 1'b0;
            memBus.ReadAddr     <= PC_INIT;
            PrePcOut            <= PC_INIT;
            InstOut             <= RegZero[INST_W-1:0];
            ReadShakeHands      <= 1'b0;
        end else begin
            ReadShakeHands <= 1'b0;
            case (state)
                IDLE: begin
                    NextAddr <= PC_INIT;
                    FillCnt  <= '0;
                    state    <= REQ;
                end

                REQ: begin
                    // A full cache lets the current request complete, then parks in HOLD.
                    if (CacheFull) begin
                        StopPend <= 1'b1;
                    end
                    if (reqFire) begin
                        memBus.ReadReqValid <= 1'b0;
                        PendAddr            <= memBus.ReadAddr;
                        state               <= WAIT;
                        if (CacheMissing) begin
                            Restart     <= 1'b1;
                            RestartAddr <= missAddr;
                        end
                    end else if (CacheMissing) begin
                        memBus.ReadReqValid <= 1'b0;
                        NextAddr            <= missAddr;
                        FillCnt             <= '0;
                        StopPend            <= 1'b0;
                    end else begin
                        memBus.ReadReqValid <= 1'b1;
                        memBus.ReadAddr     <= NextAddr;
                    end
                end

                WAIT: begin
                    if (CacheFull) begin
                        StopPend <= 1'b1;
                    end
                    if (CacheMissing && memBus.ReadRespValid) begin
                        NextAddr <= missAddr;
                        FillCnt  <= '0;
                        Restart  <= 1'b0;
                        StopPend <= 1'b0;
                        state    <= REQ;
                    end else if (CacheMissing) begin
                        // The bus still owes us a response; remember where to restart once it lands.
                        Restart     <= 1'b1;
                        RestartAddr <= missAddr;
                    end else if (memBus.ReadRespValid) begin
                        if (Restart) begin
                            NextAddr <= RestartAddr;
                            FillCnt  <= '0;
                            Restart  <= 1'b0;
                            StopPend <= 1'b0;
                            state    <= REQ;
                        end else begin
                            ReadShakeHands <= 1'b1;
                            InstOut        <= memBus.ReadRespData;
                            PrePcOut       <= PendAddr;
                            NextAddr       <= NextAddr + ADDR_W'(4);
                            FillCnt        <= FillCnt + CNT_W'(1);
                            StopPend       <= 1'b0;
                            state          <= (lastFill || CacheFull || StopPend) ? HOLD : REQ;
                        end
                    end
                end

                HOLD: begin
                    if (CacheMissing) begin
                        NextAddr <= missAddr;
                        FillCnt  <= '0;
                        StopPend <= 1'b0;
                        state    <= REQ;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pre_pc.sv
// Scoreboard bench for pre_pc: directed fills, stalls, misses, early full and mid-fill reset.
module tb_pre_pc;
    import pre_pc_pkg::*;

    localparam logic [63:0] PC0 = 64'h8000_0000;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [63:0] PcIn = '0;
    logic        CacheFull = 1'b0;
    logic        CacheMissing = 1'b0;
    logic [63:0] PrePcOut;
    logic [31:0] InstOut;
    logic        ReadShakeHands;

    pre_pc_if bus();

    pre_pc dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .PcIn           (PcIn),
        .CacheFull      (CacheFull),
        .CacheMissing   (CacheMissing),
        .memBus         (bus),
        .PrePcOut       (PrePcOut),
        .InstOut        (InstOut),
        .ReadShakeHands (ReadShakeHands)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] inst;
    } fillT;

    fillT expQ[$];
    int   checks    = 0;
    int   failures  = 0;
    int   strobeCnt = 0;
    int   respDelay = 0;

    // Memory contents; the word at 0x8000_3000 is the one a restart must throw away.
    function automatic logic [31:0] memWord(input logic [63:0] a);
        if (a == 64'h8000_3000) return 32'hDEAD_BEEF;
        return a[31:0] ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic pushFills(input logic [63:0] base, input int n);
        fillT e;
        for (int i = 0; i < n; i++) begin
            e.addr = base + 64'(4 * i);
            e.inst = memWord(e.addr);
            expQ.push_back(e);
        end
    endtask

    task automatic pulseMiss(input logic [63:0] pc);
        PcIn         = pc;
        CacheMissing = 1'b1;
        tick();
        CacheMissing = 1'b0;
    endtask

    task automatic waitDrained(input string name, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(expQ.size()), 64'd0);
    endtask

    task automatic waitStrobes(input string name, input int target, input int budget);
        int n = 0;
        while (strobeCnt < target && n < budget) begin
            tick();
            n++;
        end
        check(name, 64'(strobeCnt), 64'(target));
    endtask

    task automatic expectNoReq(input string name, input int cycles);
        int seen = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (bus.ReadReqValid) seen++;
        end
        check(name, 64'(seen), 64'd0);
    endtask

    task automatic expectNextReq(input string name, input logic [63:0] exp, input int budget);
        int n = 0;
        while (!bus.ReadReqValid && n < budget) begin
            tick();
            n++;
        end
        check({name, "_vld"}, {63'b0, bus.ReadReqValid}, 64'd1);
        check(name, bus.ReadAddr, exp);
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, "_req_vld"}, {63'b0, bus.ReadReqValid}, 64'd0);
        check({tag, "_read_addr"}, bus.ReadAddr, PC0);
        check({tag, "_prepc"}, PrePcOut, PC0);
        check({tag, "_inst"}, {32'b0, InstOut}, 64'd0);
        check({tag, "_strobe"}, {63'b0, ReadShakeHands}, 64'd0);
    endtask

    // IDLE takes one cycle, so valid is first seen after the second edge with Rst low.
    task automatic resetRelease(input string name);
        int k = 0;
        Rst = 1'b0;
        while (!bus.ReadReqValid && k < 10) begin
            tick();
            k++;
        end
        check(name, 64'(k), 64'd2);
    endtask

    // Bus model: single outstanding read, response respDelay cycles after acceptance.
    initial begin
        logic        hs;
        logic        rstS;
        logic [63:0] hsAddr;
        logic        pend;
        int          cnt;
        logic [63:0] pAddr;
        pend = 1'b0;
        cnt  = 0;
        pAddr = '0;
        bus.ReadRespValid = 1'b0;
        bus.ReadRespData  = '0;
        forever begin
            @(negedge Clk);
            hs     = bus.ReadReqValid && bus.ReadReqReady;
            hsAddr = bus.ReadAddr;
            rstS   = Rst;
            @(posedge Clk);
            #1;
            bus.ReadRespValid = 1'b0;
            if (rstS) begin
                pend = 1'b0;
            end else begin
                if (hs) begin
                    pend  = 1'b1;
                    cnt   = respDelay;
                    pAddr = hsAddr;
                end
                if (pend) begin
                    if (cnt == 0) begin
                        bus.ReadRespValid = 1'b1;
                        bus.ReadRespData  = memWord(pAddr);
                        pend = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    // Monitor: every strobe is matched against the head of the expected queue.
    initial begin
        logic prev;
        fillT e;
        prev = 1'b0;
        forever begin
            @(negedge Clk);
            if (bus.ReadReqValid) begin
                check("addr_align", {62'b0, bus.ReadAddr[1:0]}, 64'd0);
            end
            if (ReadShakeHands) begin
                strobeCnt++;
                check("strobe_gap", {63'b0, prev}, 64'd0);
                if (expQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe: addr 0x%0h inst 0x%0h with nothing expected", PrePcOut, InstOut);
                end else begin
                    e = expQ.pop_front();
                    check("fill_addr", PrePcOut, e.addr);
                    check("fill_inst", {32'b0, InstOut}, {32'b0, e.inst});
                end
            end
            prev = ReadShakeHands;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        bus.ReadReqReady = 1'b1;
        repeat (3) tick();
        checkResetValues("rst0");

        // Zero-wait bus: full line from PC_INIT, then idle.
        pushFills(PC0, 16);
        resetRelease("t1_first_req_cycle");
        waitDrained("t1_drain", 300);
        expectNoReq("t1_hold_noreq", 20);

        // Miss from HOLD with a stalled bus.
        bus.ReadReqReady = 1'b0;
        pushFills(64'h8000_1004, 16);
        pulseMiss(64'h8000_1006);
        expectNextReq("t3_miss_addr", 64'h8000_1004, 10);
        base = strobeCnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_stall_vld", {63'b0, bus.ReadReqValid}, 64'd1);
            check("t3_stall_addr", bus.ReadAddr, 64'h8000_1004);
        end
        check("t3_no_strobe", 64'(strobeCnt), 64'(base));
        bus.ReadReqReady = 1'b1;
        waitDrained("t3_drain", 300);
        expectNoReq("t3_hold_noreq", 20);

        // Miss while waiting on a slow response.
        respDelay = 3;
        pulseMiss(64'h8000_3000);
        begin
            int n = 0;
            while (!(bus.ReadReqValid && bus.ReadReqReady) && n < 10) begin
                tick();
                n++;
            end
        end
        check("t4_req_addr", bus.ReadAddr, 64'h8000_3000);
        tick();
        pulseMiss(64'h8000_2000);
        respDelay = 0;
        pushFills(64'h8000_2000, 16);
        expectNextReq("t4_restart_addr", 64'h8000_2000, 20);
        waitDrained("t4_drain", 300);
        expectNoReq("t4_hold_noreq", 20);

        // CacheFull after five fills: the sixth in-flight word still lands.
        pushFills(64'h8000_4000, 6);
        base = strobeCnt;
        pulseMiss(64'h8000_4000);
        waitStrobes("t5_five_fills", base + 5, 100);
        CacheFull = 1'b1;
        waitDrained("t5_drain", 50);
        expectNoReq("t5_hold_noreq", 20);
        check("t5_fill_count", 64'(strobeCnt - base), 64'd6);
        CacheFull = 1'b0;
        tick();

        // Reset after the seventh word of a fill.
        pushFills(64'h8000_5000, 7);
        base = strobeCnt;
        pulseMiss(64'h8000_5000);
        waitStrobes("t6_seven_fills", base + 7, 100);
        Rst = 1'b1;
        tick();
        checkResetValues("t6_rst");
        check("t6_queue_empty", 64'(expQ.size()), 64'd0);
        tick();
        pushFills(PC0, 16);
        resetRelease("t6_first_req_cycle");
        waitDrained("t6_drain", 300);
        expectNoReq("t6_hold_noreq", 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
